// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - periodic serial ADC reader with sign-magnitude output
//
// Each sample tick starts one 16-bit read from the ADC over cs_n/sclk/sdo.
// The word is converted from two's complement to sign-magnitude and presented
// on x together with a one-cycle x_valid strobe. Every output is registered.
module adc_sampler #(
   parameter int DIV    = 2,
   parameter int PERIOD = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        adc_sdo,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [15:0] x,
   output logic        x_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [PW-1:0] r_per;
   logic [DW-1:0] r_div;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_sh;
   logic        r_cs_n;
   logic        r_sclk;
   logic [15:0] r_x;
   logic        r_valid;
   logic        r_busy;
   logic        r_overrun;

   logic        w_tick;
   logic        w_div_end;
   logic        w_rise;
   logic        w_fall;
   logic        w_last;
   logic        w_cs_n_nxt;
   logic        w_busy_nxt;
   logic [15:0] w_neg;
   logic [15:0] w_conv;

   assign w_tick    = en && (r_per == PW'(PERIOD - 1));
   assign w_div_end = (r_div == DW'(DIV - 1));
   assign w_rise    = (r_state == S_SHIFT) && w_div_end && !r_sclk;
   assign w_fall    = (r_state == S_SHIFT) && w_div_end && r_sclk;
   // The falling toggle after the 16th rising edge ends the frame.
   assign w_last    = w_fall && (r_bit_cnt == 5'd16);

   // Free-running sample period counter; parked at zero while disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_per <= '0;
      end else if (!en) begin
         r_per <= '0;
      end else if (r_per == PW'(PERIOD - 1)) begin
         r_per <= '0;
      end else begin
         r_per <= r_per + PW'(1);
      end
   end

   // State register plus the registered strobes derived from the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cs_n  <= w_cs_n_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic; chip select and busy follow the state being entered.
   always_comb begin
      w_next     = r_state;
      w_cs_n_nxt = 1'b1;
      w_busy_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      w_cs_n_nxt = (w_next != S_SHIFT);
      w_busy_nxt = (w_next != S_IDLE);
   end

   // sclk half-period divider; only runs while shifting.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div <= '0;
      end else if (r_state != S_SHIFT || w_div_end) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   // Serial clock: toggles at each divider wrap, forced low outside SHIFT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sclk <= 1'b0;
      end else if (r_state != S_SHIFT) begin
         r_sclk <= 1'b0;
      end else if (w_div_end) begin
         r_sclk <= ~r_sclk;
      end
   end

   // Counts sclk rising edges within the current frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bit_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_bit_cnt <= '0;
      end else if (w_rise) begin
         r_bit_cnt <= r_bit_cnt + 5'd1;
      end
   end

   // Capture sdo MSB first on every sclk rising edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh <= '0;
      end else if (w_rise) begin
         r_sh <= {r_sh[14:0], adc_sdo};
      end
   end

   // Two's complement to sign-magnitude; the most negative code saturates.
   always_comb begin
      w_neg  = 16'(~r_sh + 16'd1);
      w_conv = r_sh;
      if (r_sh[15]) begin
         if (r_sh == 16'h8000) begin
            w_conv = 16'hFFFF;
         end else begin
            w_conv = {1'b1, w_neg[14:0]};
         end
      end
   end

   // Output sample register and its one-cycle valid strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_x     <= '0;
         r_valid <= 1'b0;
      end else if (r_state == S_DONE) begin
         r_x     <= w_conv;
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   // Sticky flag for ticks that arrive while a conversion is in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_overrun <= 1'b0;
      end else if (w_tick && r_state != S_IDLE) begin
         r_overrun <= 1'b1;
      end
   end

   assign adc_cs_n = r_cs_n;
   assign adc_sclk = r_sclk;
   assign x        = r_x;
   assign x_valid  = r_valid;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - scoreboard bench for adc_sampler
module tb_adc_sampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // DUT A: default timing
   logic        rst_a, en_a, sdo_a, cs_a, sclk_a, xv_a, busy_a, ovr_a;
   logic [15:0] x_a;
   // DUT B: short period for overrun
   logic        rst_b, en_b, sdo_b, cs_b, sclk_b, xv_b, busy_b, ovr_b;
   logic [15:0] x_b;

   adc_sampler #(.DIV(2), .PERIOD(256)) u_dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .adc_sdo(sdo_a),
      .adc_cs_n(cs_a), .adc_sclk(sclk_a), .x(x_a), .x_valid(xv_a),
      .busy(busy_a), .overrun(ovr_a)
   );

   adc_sampler #(.DIV(2), .PERIOD(40)) u_dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .adc_sdo(sdo_b),
      .adc_cs_n(cs_b), .adc_sclk(sclk_b), .x(x_b), .x_valid(xv_b),
      .busy(busy_b), .overrun(ovr_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ADC models: load a word on cs fall, present MSB, advance on sclk fall
   logic [15:0] raw_qa[$];
   logic [15:0] raw_qb[$];
   logic [15:0] exp_qa[$];
   logic [15:0] exp_qb[$];
   logic [15:0] sh_a = 16'h0;
   logic [15:0] sh_b = 16'h0;
   logic        force_a = 1'b1;
   logic        tog_a = 1'b0;

   assign sdo_a = force_a ? tog_a : sh_a[15];
   assign sdo_b = sh_b[15];

   always @(negedge cs_a) begin
      check("adc_a_word_available", 32'(raw_qa.size() > 0), 32'd1);
      if (raw_qa.size() > 0) sh_a = raw_qa.pop_front();
   end
   always @(negedge sclk_a) sh_a = sh_a << 1;

   always @(negedge cs_b) begin
      check("adc_b_word_available", 32'(raw_qb.size() > 0), 32'd1);
      if (raw_qb.size() > 0) sh_b = raw_qb.pop_front();
   end
   always @(negedge sclk_b) sh_b = sh_b << 1;

   // Monitors: pop expected sample whenever a DUT presents x_valid
   always @(negedge clk) begin
      if (xv_a === 1'b1) begin
         if (exp_qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL x_a_unexpected: got %0h expected no sample", x_a);
         end else begin
            check("x_a", 32'(x_a), 32'(exp_qa.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (xv_b === 1'b1) begin
         if (exp_qb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL x_b_unexpected: got %0h expected no sample", x_b);
         end else begin
            check("x_b", 32'(x_b), 32'(exp_qb.pop_front()));
         end
      end
   end

   // Wait for cs_a high then low; returns the cycle of the fall
   task automatic wait_cs_a_fall(input string name, output int fall_cyc);
      int g;
      g = 0;
      while (cs_a !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
      while (cs_a !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
      if (g >= 2000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got timeout expected cs_n fall", name);
      end
      fall_cyc = cyc;
   endtask

   task automatic wait_cs_b_fall(input string name, output int fall_cyc);
      int g;
      g = 0;
      while (cs_b !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
      while (cs_b !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
      if (g >= 2000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got timeout expected cs_n fall", name);
      end
      fall_cyc = cyc;
   endtask

   initial begin
      int t0, tf, tprev, low, rises, busy_bad, g;
      logic prev;
      logic [15:0] raws [7];
      logic [15:0] exps [6];

      raws = '{16'h0300, 16'hFF2E, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h1111, 16'hFFFE};
      exps = '{16'h0300, 16'h80D2, 16'hFFFF, 16'h8001, 16'h7FFF, 16'h8002};
      foreach (raws[i]) raw_qa.push_back(raws[i]);
      foreach (exps[i]) exp_qa.push_back(exps[i]);
      raw_qb.push_back(16'hFEDC);
      exp_qb.push_back(16'h8124);
      raw_qb.push_back(16'h0042);
      exp_qb.push_back(16'h0042);

      rst_a = 1'b0;
      en_a  = 1'b1;
      rst_b = 1'b0;
      en_b  = 1'b1;

      // Reset held for 3 cycles with sdo toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tog_a = ~tog_a;
         check("rst_cs_n", 32'(cs_a), 32'd1);
         check("rst_sclk", 32'(sclk_a), 32'd0);
         check("rst_x", 32'(x_a), 32'd0);
         check("rst_x_valid", 32'(xv_a), 32'd0);
         check("rst_busy", 32'(busy_a), 32'd0);
         check("rst_overrun", 32'(ovr_a), 32'd0);
      end
      force_a = 1'b0;
      rst_a = 1'b1;
      t0 = cyc;

      // Positive sample: tick timing, frame shape, output latency
      wait_cs_a_fall("first_tick", tf);
      check("first_cs_fall_cycle", 32'(tf - t0), 32'd256);
      low = 0;
      rises = 0;
      busy_bad = 0;
      prev = sclk_a;
      g = 0;
      while (cs_a === 1'b0 && g < 200) begin
         low++;
         if (busy_a !== 1'b1) busy_bad++;
         @(negedge clk);
         g++;
         if (sclk_a === 1'b1 && prev === 1'b0) rises++;
         prev = sclk_a;
      end
      check("cs_low_cycles", 32'(low), 32'd64);
      check("sclk_rises", 32'(rises), 32'd16);
      check("busy_in_shift", 32'(busy_bad), 32'd0);
      check("busy_in_done", 32'(busy_a), 32'd1);
      check("sclk_in_done", 32'(sclk_a), 32'd0);
      g = 0;
      while (xv_a !== 1'b1 && g < 10) begin @(negedge clk); g++; end
      check("x_valid_latency", 32'(cyc - (tf - 1)), 32'd66);
      @(negedge clk);
      check("x_valid_one_cycle", 32'(xv_a), 32'd0);
      check("busy_after_done", 32'(busy_a), 32'd0);
      check("x_holds", 32'(x_a), 32'h0300);

      // Negative, saturation, -1 and max positive samples
      tprev = tf;
      for (int i = 0; i < 4; i++) begin
         wait_cs_a_fall("periodic_tick", tf);
         check("tick_spacing", 32'(tf - tprev), 32'd256);
         tprev = tf;
      end

      // Reset in the 20th SHIFT cycle
      wait_cs_a_fall("abort_tick", tf);
      repeat (19) @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      check("abort_cs_n", 32'(cs_a), 32'd1);
      check("abort_sclk", 32'(sclk_a), 32'd0);
      check("abort_x", 32'(x_a), 32'd0);
      check("abort_x_valid", 32'(xv_a), 32'd0);
      check("abort_busy", 32'(busy_a), 32'd0);
      rst_a = 1'b1;
      t0 = cyc;
      wait_cs_a_fall("tick_after_abort", tf);
      check("tick_after_abort_cycle", 32'(tf - t0), 32'd256);

      // Disable mid-SHIFT: sample completes, then no further activity
      repeat (10) @(negedge clk);
      en_a = 1'b0;
      g = 0;
      while (xv_a !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      check("en_off_sample_done", 32'(xv_a), 32'd1);
      low = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (cs_a !== 1'b1 || busy_a !== 1'b0) low++;
      end
      check("en_off_idle_cycles", 32'(low), 32'd0);
      check("overrun_a_clear", 32'(ovr_a), 32'd0);

      // Overrun on the short-period instance
      rst_b = 1'b1;
      t0 = cyc;
      wait_cs_b_fall("b_first_tick", tf);
      check("b_first_cs_fall", 32'(tf - t0), 32'd40);
      check("b_overrun_before", 32'(ovr_b), 32'd0);
      g = 0;
      while (ovr_b !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      check("b_overrun_cycle", 32'(cyc - t0), 32'd80);
      check("b_cs_low_at_overrun", 32'(cs_b), 32'd0);
      wait_cs_b_fall("b_second_accept", tf);
      check("b_second_cs_fall", 32'(tf - t0), 32'd120);
      check("b_overrun_sticky", 32'(ovr_b), 32'd1);
      g = 0;
      while (xv_b !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      @(negedge clk);
      check("b_overrun_still", 32'(ovr_b), 32'd1);
      rst_b = 1'b0;
      @(negedge clk);
      check("b_overrun_reset", 32'(ovr_b), 32'd0);

      check("a_samples_outstanding", 32'(exp_qa.size()), 32'd0);
      check("b_samples_outstanding", 32'(exp_qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
